clken_synth: RTL

- Multi-channel fractional clock-enable synthesiser running entirely in the refclk domain.
- Each channel produces a single-cycle enable pulse train at an average rate of refclk × NUM/DEN using a phase accumulator, plus a divided toggle output.
- Unlike a fixed PLL output, ratios are reprogrammable at runtime through a valid/ready config port.
- A global settle timer drives `locked`. Cores use it to derive pixel/sample rates (e.g. 23.75 MHz from 74.25 MHz) without spending another PLL.

---
 rtl/clken_synth.sv | 135 +++++++++++++
 1 files changed

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser: per-channel phase accumulators
// produce enable pulses at refclk*NUM/DEN, with a runtime config port and lock timer.
`timescale 1ns/1ps

module clken_synth #(
   parameter int NUM_CH     = 2,
   parameter int ACC_W      = 16,
   parameter int LOCK_DELAY = 16,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W     = $clog2(LOCK_DELAY + 1)
) (
   input  logic              i_refclk,
   input  logic              i_rst,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [ACC_W-1:0]  i_cfg_num,
   input  logic [ACC_W-1:0]  i_cfg_den,
   output logic              o_cfg_err,
   input  logic [NUM_CH-1:0] i_ch_en,
   output logic [NUM_CH-1:0] o_clken,
   output logic [NUM_CH-1:0] o_clk_tog,
   output logic              o_locked
);

   // state    | meaning
   // S_UNCFG  | no ratio accepted since reset, locked low
   // S_SETTLE | counting LOCK_DELAY cycles since the last accepted config
   // S_LOCKED | all ratios settled, locked high
   typedef enum logic [1:0] {S_UNCFG, S_SETTLE, S_LOCKED} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_cfg_ready, r_cfg_err, r_locked;
   logic             w_hs, w_bad, w_accept;

   assign w_hs     = i_cfg_valid & r_cfg_ready;
   assign w_bad    = (i_cfg_num > i_cfg_den) || (i_cfg_den == '0) || (int'(i_cfg_ch) >= NUM_CH);
   assign w_accept = w_hs & ~w_bad;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [ACC_W-1:0] r_num, r_den, r_acc;
      logic             r_hit, r_clken, r_tog;
      logic [ACC_W:0]   w_sum, w_diff;
      logic             w_wrap, w_sel;

      assign w_sum  = {1'b0, r_acc} + {1'b0, r_num};
      assign w_diff = w_sum - {1'b0, r_den};
      assign w_wrap = (w_sum >= {1'b0, r_den});
      assign w_sel  = w_accept && (int'(i_cfg_ch) == k);

      // r_hit holds the wrap of the latest update; it freezes with the accumulator
      // while the channel is disabled so no pulse is lost across a pause.
      always_ff @(posedge i_refclk or posedge i_rst) begin
         if (i_rst) begin
            r_num   <= '0;
            r_den   <= ACC_W'(1);
            r_acc   <= '0;
            r_hit   <= 1'b0;
            r_clken <= 1'b0;
            r_tog   <= 1'b0;
         end else if (w_sel) begin
            r_num   <= i_cfg_num;
            r_den   <= i_cfg_den;
            r_acc   <= '0;
            r_hit   <= 1'b0;
            r_clken <= 1'b0;
         end else if (i_ch_en[k]) begin
            r_acc   <= w_wrap ? w_diff[ACC_W-1:0] : w_sum[ACC_W-1:0];
            r_hit   <= w_wrap;
            r_clken <= r_hit;
            r_tog   <= r_tog ^ r_hit;
         end else begin
            r_clken <= 1'b0;
         end
      end

      assign o_clken[k]   = r_clken;
      assign o_clk_tog[k] = r_tog;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_UNCFG: begin
            if (w_accept) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = '0;
            end
         end
         S_SETTLE: begin
            if (w_accept) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_W'(LOCK_DELAY - 1)) begin
               w_state_nxt = S_LOCKED;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_LOCKED: begin
            if (w_accept) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_UNCFG;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // locked registers the next state so it rises LOCK_DELAY edges after the accept edge
   always_ff @(posedge i_refclk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_UNCFG;
         r_cnt       <= '0;
         r_cfg_ready <= 1'b1;
         r_cfg_err   <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cfg_ready <= ~w_hs;
         r_cfg_err   <= w_hs & w_bad;
         r_locked    <= (w_state_nxt == S_LOCKED);
      end
   end

   assign o_cfg_ready = r_cfg_ready;
   assign o_cfg_err   = r_cfg_err;
   assign o_locked    = r_locked;

endmodule
